// File: rtl/alu_issue_pkg.sv
// Shared constants, op codes and the ID/EX bundle for the ALU issue stage.
// Also provides the 16-bit immediate extension helpers.
package alu_issue_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [3:0] ALU_SLL  = 4'b0000;
    localparam logic [3:0] ALU_SRL  = 4'b0001;
    localparam logic [3:0] ALU_SRA  = 4'b0010;
    localparam logic [3:0] ALU_SLLV = 4'b0011;
    localparam logic [3:0] ALU_SRLV = 4'b0100;
    localparam logic [3:0] ALU_SRAV = 4'b0101;
    localparam logic [3:0] ALU_ADD  = 4'b0110;
    localparam logic [3:0] ALU_SUB  = 4'b0111;
    localparam logic [3:0] ALU_AND  = 4'b1000;
    localparam logic [3:0] ALU_OR   = 4'b1001;
    localparam logic [3:0] ALU_XOR  = 4'b1010;
    localparam logic [3:0] ALU_NOR  = 4'b1011;
    localparam logic [3:0] ALU_SLT  = 4'b1100;
    localparam logic [3:0] ALU_SLTU = 4'b1101;
    localparam logic [3:0] ALU_ILL  = 4'b1111;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ADDIU = 6'h09;
    localparam logic [5:0] OPC_SLTI  = 6'h0A;
    localparam logic [5:0] OPC_SLTIU = 6'h0B;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_XORI  = 6'h0E;
    localparam logic [5:0] OPC_LUI   = 6'h0F;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef struct packed {
        logic [3:0]        op;
        logic [DATA_W-1:0] in1;
        logic [DATA_W-1:0] in2;
        logic [4:0]        shamt;
        logic [ADDR_W-1:0] dest;
        logic              reg_write;
        logic              store;
        logic [DATA_W-1:0] store_data;
        logic              illegal;
    } id_ex_t;

    function automatic logic [DATA_W-1:0] sext16(input logic [15:0] imm);
        return {{(DATA_W-16){imm[15]}}, imm};
    endfunction

    function automatic logic [DATA_W-1:0] zext16(input logic [15:0] imm);
        return {{(DATA_W-16){1'b0}}, imm};
    endfunction

endpackage

// File: rtl/alu_issue_stage_decode.sv
// alu_ctrl_decode: combinational decode of MIPS R/I fields into an id_ex_t.
// Ports: opcode/funct/shamt/imm, rs/rt data, rt/rd addresses in; dec out.
module alu_ctrl_decode
    import alu_issue_pkg::*;
(
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic [4:0]        shamt,
    input  logic [15:0]       imm,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    output id_ex_t            dec
);

    logic is_shift;
    logic legal;

    always_comb begin
        dec           = '0;
        is_shift      = 1'b0;
        legal         = 1'b1;
        dec.in1       = rs_data;
        dec.in2       = rt_data;
        dec.dest      = rt_addr;
        dec.reg_write = 1'b1;
        if (opcode == OPC_RTYPE) begin
            dec.dest = rd_addr;
            unique case (funct)
                FN_SLL:  begin dec.op = ALU_SLL;  is_shift = 1'b1; end
                FN_SRL:  begin dec.op = ALU_SRL;  is_shift = 1'b1; end
                FN_SRA:  begin dec.op = ALU_SRA;  is_shift = 1'b1; end
                FN_SLLV: begin dec.op = ALU_SLLV; is_shift = 1'b1; end
                FN_SRLV: begin dec.op = ALU_SRLV; is_shift = 1'b1; end
                FN_SRAV: begin dec.op = ALU_SRAV; is_shift = 1'b1; end
                FN_ADD, FN_ADDU: dec.op = ALU_ADD;
                FN_SUB, FN_SUBU: dec.op = ALU_SUB;
                FN_AND:  dec.op = ALU_AND;
                FN_OR:   dec.op = ALU_OR;
                FN_XOR:  dec.op = ALU_XOR;
                FN_NOR:  dec.op = ALU_NOR;
                FN_SLT:  dec.op = ALU_SLT;
                FN_SLTU: dec.op = ALU_SLTU;
                default: legal = 1'b0;
            endcase
            // Shifts operate on rt; rs carries the variable amount.
            if (is_shift) begin
                dec.in1   = rt_data;
                dec.in2   = rs_data;
                dec.shamt = shamt;
            end
        end else begin
            unique case (opcode)
                OPC_ADDI, OPC_ADDIU: begin
                    dec.op  = ALU_ADD;
                    dec.in2 = sext16(imm);
                end
                OPC_SLTI: begin
                    dec.op  = ALU_SLT;
                    dec.in2 = sext16(imm);
                end
                OPC_SLTIU: begin
                    dec.op  = ALU_SLTU;
                    dec.in2 = sext16(imm);
                end
                OPC_ANDI: begin
                    dec.op  = ALU_AND;
                    dec.in2 = zext16(imm);
                end
                OPC_ORI: begin
                    dec.op  = ALU_OR;
                    dec.in2 = zext16(imm);
                end
                OPC_XORI: begin
                    dec.op  = ALU_XOR;
                    dec.in2 = zext16(imm);
                end
                // lui is a left shift of the immediate by 16.
                OPC_LUI: begin
                    dec.op    = ALU_SLL;
                    dec.in1   = zext16(imm);
                    dec.in2   = '0;
                    dec.shamt = 5'd16;
                end
                OPC_LW: begin
                    dec.op  = ALU_ADD;
                    dec.in2 = sext16(imm);
                end
                OPC_SW: begin
                    dec.op         = ALU_ADD;
                    dec.in2        = sext16(imm);
                    dec.reg_write  = 1'b0;
                    dec.store      = 1'b1;
                    dec.store_data = rt_data;
                end
                OPC_BEQ, OPC_BNE: begin
                    dec.op        = ALU_SUB;
                    dec.reg_write = 1'b0;
                end
                default: legal = 1'b0;
            endcase
        end
        if (!legal) begin
            dec         = '0;
            dec.op      = ALU_ILL;
            dec.illegal = 1'b1;
        end
        // r0 is hardwired to zero, so a write there is dropped.
        if (dec.dest == '0)
            dec.reg_write = 1'b0;
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX pipeline register with ALU control decode and valid/ready handshake.
// Ports: ID fields + id_valid/id_ready in, flush, ALU controls + ex_valid/ex_ready out.
module alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter int XLEN   = DATA_W,
    parameter int REG_AW = ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [5:0]        id_opcode,
    input  logic [5:0]        id_funct,
    input  logic [4:0]        id_shamt,
    input  logic [15:0]       id_imm,
    input  logic [XLEN-1:0]   id_rs_data,
    input  logic [XLEN-1:0]   id_rt_data,
    input  logic [REG_AW-1:0] id_rt_addr,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic              flush,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [3:0]        alu_op,
    output logic [XLEN-1:0]   alu_in1,
    output logic [XLEN-1:0]   alu_in2,
    output logic [4:0]        alu_shamt,
    output logic [REG_AW-1:0] ex_dest,
    output logic              ex_reg_write,
    output logic              ex_store,
    output logic [XLEN-1:0]   ex_store_data,
    output logic              ex_illegal
);

    id_ex_t dec;
    id_ex_t q;
    logic   load;

    alu_ctrl_decode u_decode (
        .opcode  (id_opcode),
        .funct   (id_funct),
        .shamt   (id_shamt),
        .imm     (id_imm),
        .rs_data (id_rs_data),
        .rt_data (id_rt_data),
        .rt_addr (id_rt_addr),
        .rd_addr (id_rd_addr),
        .dec     (dec)
    );

    assign id_ready = !ex_valid || ex_ready;
    // A flushed incoming instruction is dropped, so the payload is not loaded.
    assign load     = id_valid && id_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
            q        <= '0;
        end else begin
            if (flush)
                ex_valid <= 1'b0;
            else if (load)
                ex_valid <= 1'b1;
            else if (ex_ready)
                ex_valid <= 1'b0;
            if (load)
                q <= dec;
        end
    end

    assign alu_op        = q.op;
    assign alu_in1       = q.in1;
    assign alu_in2       = q.in2;
    assign alu_shamt     = q.shamt;
    assign ex_dest       = q.dest;
    assign ex_reg_write  = q.reg_write;
    assign ex_store      = q.store;
    assign ex_store_data = q.store_data;
    assign ex_illegal    = q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed cases plus random traffic
// compared against a behavioural model of the stage.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic        id_ready;
    logic [5:0]  id_opcode;
    logic [5:0]  id_funct;
    logic [4:0]  id_shamt;
    logic [15:0] id_imm;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [4:0]  id_rt_addr;
    logic [4:0]  id_rd_addr;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [3:0]  alu_op;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [4:0]  alu_shamt;
    logic [4:0]  ex_dest;
    logic        ex_reg_write;
    logic        ex_store;
    logic [31:0] ex_store_data;
    logic        ex_illegal;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_opcode     (id_opcode),
        .id_funct      (id_funct),
        .id_shamt      (id_shamt),
        .id_imm        (id_imm),
        .id_rs_data    (id_rs_data),
        .id_rt_data    (id_rt_data),
        .id_rt_addr    (id_rt_addr),
        .id_rd_addr    (id_rd_addr),
        .flush         (flush),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .alu_op        (alu_op),
        .alu_in1       (alu_in1),
        .alu_in2       (alu_in2),
        .alu_shamt     (alu_shamt),
        .ex_dest       (ex_dest),
        .ex_reg_write  (ex_reg_write),
        .ex_store      (ex_store),
        .ex_store_data (ex_store_data),
        .ex_illegal    (ex_illegal)
    );

    typedef struct {
        bit          v;
        logic [3:0]  op;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [31:0] sd;
        logic [4:0]  sh;
        logic [4:0]  dest;
        bit          rw;
        bit          st;
        bit          ill;
    } exp_t;

    exp_t m;
    int   n_chk  = 0;
    int   n_fail = 0;

    localparam logic [5:0] OPC_TAB [14] = '{
        6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C,
        6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05};
    localparam logic [5:0] FN_TAB [17] = '{
        6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22,
        6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h3F};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t ref_decode(
        input logic [5:0] opc, input logic [5:0] fn, input logic [4:0] sh,
        input logic [15:0] imm, input logic [31:0] rs, input logic [31:0] rt,
        input logic [4:0] rta, input logic [4:0] rda);
        exp_t r = '{default:0};
        bit ok = 1;
        logic [31:0] sx;
        logic [31:0] zx;
        sx = 32'($signed(imm));
        zx = {16'h0, imm};
        if (opc == 6'h00) begin
            r.dest = rda; r.rw = 1; r.in1 = rs; r.in2 = rt;
            case (fn)
                6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07: begin
                    r.in1 = rt; r.in2 = rs; r.sh = sh;
                    r.op = (fn == 6'h00) ? 4'd0 : (fn == 6'h02) ? 4'd1 :
                           (fn == 6'h03) ? 4'd2 : (fn == 6'h04) ? 4'd3 :
                           (fn == 6'h06) ? 4'd4 : 4'd5;
                end
                6'h20, 6'h21: r.op = 4'd6;
                6'h22, 6'h23: r.op = 4'd7;
                6'h24: r.op = 4'd8;
                6'h25: r.op = 4'd9;
                6'h26: r.op = 4'd10;
                6'h27: r.op = 4'd11;
                6'h2A: r.op = 4'd12;
                6'h2B: r.op = 4'd13;
                default: ok = 0;
            endcase
        end else begin
            r.dest = rta; r.rw = 1; r.in1 = rs;
            case (opc)
                6'h08, 6'h09: begin r.op = 4'd6;  r.in2 = sx; end
                6'h0A:        begin r.op = 4'd12; r.in2 = sx; end
                6'h0B:        begin r.op = 4'd13; r.in2 = sx; end
                6'h0C:        begin r.op = 4'd8;  r.in2 = zx; end
                6'h0D:        begin r.op = 4'd9;  r.in2 = zx; end
                6'h0E:        begin r.op = 4'd10; r.in2 = zx; end
                6'h0F: begin r.op = 4'd0; r.in1 = zx; r.in2 = 0; r.sh = 16; end
                6'h23:        begin r.op = 4'd6;  r.in2 = sx; end
                6'h2B: begin
                    r.op = 4'd6; r.in2 = sx; r.rw = 0; r.st = 1; r.sd = rt;
                end
                6'h04, 6'h05: begin r.op = 4'd7; r.in2 = rt; r.rw = 0; end
                default: ok = 0;
            endcase
        end
        if (!ok) begin
            r = '{default:0};
            r.op = 4'hF;
            r.ill = 1;
        end
        if (r.dest == 0) r.rw = 0;
        r.v = 1;
        return r;
    endfunction

    function automatic exp_t model_next(input exp_t cur);
        exp_t n = cur;
        if (flush)
            n.v = 0;
        else if (id_valid && (!cur.v || ex_ready))
            n = ref_decode(id_opcode, id_funct, id_shamt, id_imm,
                           id_rs_data, id_rt_data, id_rt_addr, id_rd_addr);
        else if (ex_ready)
            n.v = 0;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '{default:0};
        else        m <= model_next(m);
    end

    task automatic check_all();
        chk("ex_valid", ex_valid, m.v);
        chk("id_ready", id_ready, !m.v || ex_ready);
        if (m.v) begin
            chk("alu_op", alu_op, m.op);
            chk("alu_in1", alu_in1, m.in1);
            chk("alu_in2", alu_in2, m.in2);
            chk("alu_shamt", alu_shamt, m.sh);
            chk("reg_write", ex_reg_write, m.rw);
            chk("store", ex_store, m.st);
            chk("illegal", ex_illegal, m.ill);
            if (m.rw) chk("dest", ex_dest, m.dest);
            if (m.st) chk("store_data", ex_store_data, m.sd);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_all();
    endtask

    task automatic rtype(input logic [5:0] fn, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [4:0] rd,
                         input logic [4:0] sh);
        id_opcode = 6'h00; id_funct = fn; id_shamt = sh;
        id_rs_data = rs; id_rt_data = rt; id_rd_addr = rd;
        id_rt_addr = 5'd9; id_imm = {rd, sh, fn};
    endtask

    task automatic itype(input logic [5:0] opc, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [4:0] rta,
                         input logic [15:0] imm);
        id_opcode = opc; id_imm = imm; id_rs_data = rs; id_rt_data = rt;
        id_rt_addr = rta; id_funct = imm[5:0]; id_shamt = imm[10:6];
        id_rd_addr = imm[15:11];
    endtask

    task automatic rand_instr();
        if ($urandom % 8 == 0) begin
            id_opcode = 6'($urandom);
            id_funct  = 6'($urandom);
        end else begin
            id_opcode = OPC_TAB[$urandom % 14];
            id_funct  = FN_TAB[$urandom % 17];
        end
        id_shamt   = 5'($urandom);
        id_imm     = 16'($urandom);
        id_rs_data = $urandom;
        id_rt_data = $urandom;
        id_rt_addr = 5'($urandom);
        id_rd_addr = 5'($urandom);
    endtask

    initial begin
        rst_n = 1'b0; id_valid = 1'b0; ex_ready = 1'b1; flush = 1'b0;
        rtype(6'h20, 0, 0, 0, 0);
        #12;
        chk("rst_valid", ex_valid, 0);
        chk("rst_op", alu_op, 0);
        chk("rst_ready", id_ready, 1);
        chk("rst_in1", alu_in1, 0);
        chk("rst_rw", ex_reg_write, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) cycle();
        chk("post_rst_op", alu_op, 0);
        chk("post_rst_in2", alu_in2, 0);

        rtype(6'h20, 5, 7, 3, 0); id_valid = 1'b1;
        cycle();
        chk("add_valid", ex_valid, 1);
        chk("add_op", alu_op, 4'b0110);
        chk("add_in1", alu_in1, 5);
        chk("add_in2", alu_in2, 7);
        chk("add_dest", ex_dest, 3);
        chk("add_rw", ex_reg_write, 1);

        itype(6'h08, 1, 32'hAAAA, 2, 16'hFFFF);
        cycle();
        chk("addi_in2", alu_in2, 32'hFFFFFFFF);
        itype(6'h0C, 1, 32'hAAAA, 2, 16'hFFFF);
        cycle();
        chk("andi_in2", alu_in2, 32'h0000FFFF);
        chk("andi_op", alu_op, 4'b1000);

        rtype(6'h03, 9, 32'h80000000, 4, 4);
        cycle();
        chk("sra_in1", alu_in1, 32'h80000000);
        chk("sra_op", alu_op, 4'b0010);
        chk("sra_sh", alu_shamt, 4);
        itype(6'h0F, 32'h55, 0, 6, 16'h1234);
        cycle();
        chk("lui_in1", alu_in1, 32'h1234);
        chk("lui_sh", alu_shamt, 16);

        rtype(6'h21, 11, 22, 5, 0);
        cycle();
        ex_ready = 1'b0;
        rtype(6'h22, 33, 44, 6, 0);
        repeat (3) begin
            cycle();
            chk("stall_ready", id_ready, 0);
            chk("stall_in1", alu_in1, 11);
            chk("stall_op", alu_op, 4'b0110);
        end
        ex_ready = 1'b1; flush = 1'b1;
        cycle();
        chk("flush_valid", ex_valid, 0);
        flush = 1'b0;

        for (int i = 0; i < 4; i++) begin
            rtype(6'h20, 100 + i, 1, 7, 0);
            cycle();
            chk("b2b_valid", ex_valid, 1);
            chk("b2b_in1", alu_in1, 100 + i);
        end
        rtype(6'h3F, 1, 2, 8, 0);
        cycle();
        chk("ill_flag", ex_illegal, 1);
        chk("ill_rw", ex_reg_write, 0);
        chk("ill_op", alu_op, 4'hF);
        id_valid = 1'b0;
        cycle();

        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                rtype(6'h20, 3, 4, 3, 0);
                id_valid = 1'b1; ex_ready = 1'b1; flush = 1'b0;
                cycle();
                ex_ready = 1'b0;
                cycle();
                rst_n = 1'b0;
                #1;
                chk("midrst_valid", ex_valid, 0);
                chk("midrst_op", alu_op, 0);
                chk("midrst_in1", alu_in1, 0);
                chk("midrst_ready", id_ready, 1);
                #2;
                rst_n = 1'b1;
                id_valid = 1'b0;
                cycle();
                chk("postrst_valid", ex_valid, 0);
            end
            rand_instr();
            id_valid = ($urandom % 5) != 0;
            ex_ready = ($urandom % 4) != 0;
            flush    = ($urandom % 20) == 0;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
